load_writeback_queue: RTL and testbench

//   Non-blocking load writeback unit: tracks up to DEPTH in-order outstanding loads, formats returned

---
 rtl/load_writeback_queue_pkg.sv | 20 ++
 rtl/load_slicer.sv | 58 +++++
 rtl/load_writeback_queue.sv | 145 ++++++++++++++
 tb/tb_load_writeback_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_writeback_queue_pkg.sv
// Shared encodings for the load writeback queue: memory access widths, signedness
// and the packed size of one queue entry.
package load_writeback_queue_pkg;

    localparam logic [3:0] MEM_WIDTH_1H_BYTE   = 4'b0001;
    localparam logic [3:0] MEM_WIDTH_1H_HALF   = 4'b0010;
    localparam logic [3:0] MEM_WIDTH_1H_WORD   = 4'b0100;
    localparam logic [3:0] MEM_WIDTH_1H_DOUBLE = 4'b1000;

    localparam logic MEM_SIGNED   = 1'b1;
    localparam logic MEM_UNSIGNED = 1'b0;

    // Entry = {live, rd_idx[4:0], width_1h[3:0], sign, byte_addr}
    function automatic int lwq_entry_w(input int xlen);
        return 1 + 5 + 4 + 1 + $clog2(xlen / 8);
    endfunction

    localparam int LWQ_ENTRY_W = lwq_entry_w(64);

endpackage

// File: rtl/load_slicer.sv
// Combinational load data formatter: picks the addressed lane out of the raw read
// word and sign- or zero-extends it to XLEN. Bad widths return 0 with illegal set.
module load_slicer
    import load_writeback_queue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]            rdata,
    input  logic [3:0]                 width_1h,
    input  logic                       sign,
    input  logic [$clog2(XLEN/8)-1:0]  byte_addr,
    output logic [XLEN-1:0]            data,
    output logic                       illegal
);

    localparam int BW = $clog2(XLEN / 8);

    logic [BW-1:0]   shift_off;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top_bit;
    logic [XLEN-1:0] lane;
    logic            msb;

    always_comb begin
        shift_off = '0;
        keep      = '0;
        illegal   = 1'b0;
        case (width_1h)
            MEM_WIDTH_1H_BYTE: begin
                shift_off = byte_addr;
                keep      = {XLEN{1'b1}} >> (XLEN - 8);
            end
            MEM_WIDTH_1H_HALF: begin
                shift_off = byte_addr & ~BW'(1);
                keep      = {XLEN{1'b1}} >> (XLEN - 16);
            end
            MEM_WIDTH_1H_WORD: begin
                shift_off = byte_addr & ~BW'(3);
                keep      = {XLEN{1'b1}} >> (XLEN - 32);
            end
            MEM_WIDTH_1H_DOUBLE: begin
                if (XLEN == 64) begin
                    keep = {XLEN{1'b1}};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // keep is a low-order mask, so its highest set bit marks the lane MSB
    assign lane    = rdata >> {shift_off, 3'b000};
    assign top_bit = keep & ~(keep >> 1);
    assign msb     = |(lane & top_bit);
    assign data    = (lane & keep) | (((sign == MEM_SIGNED) && msb) ? ~keep : '0);

endmodule

// File: rtl/load_writeback_queue.sv
// In-order outstanding-load tracker and register-file write port arbiter: load
// returns are formatted and win the port; ordinary pipe results stall behind them.
module load_writeback_queue
    import load_writeback_queue_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [4:0]                 req_rd_idx_i,
    input  logic [3:0]                 req_width_1h_i,
    input  logic                       req_sign_i,
    input  logic [$clog2(XLEN/8)-1:0]  req_byte_addr_i,
    input  logic                       rsp_valid_i,
    input  logic [XLEN-1:0]            rsp_rdata_i,
    input  logic                       pipe_valid_i,
    input  logic [4:0]                 pipe_rd_idx_i,
    input  logic [XLEN-1:0]            pipe_rd_data_i,
    output logic                       pipe_stall_o,
    output logic [XLEN-1:0]            rd_data_o,
    output logic [4:0]                 rd_idx_o,
    output logic                       rd_wr_en_o,
    output logic [31:0]                pending_o,
    output logic                       err_o
);

    localparam int BW = $clog2(XLEN / 8);
    localparam int PW = $clog2(DEPTH);

    // Handshake: a load is accepted on a cycle where req_valid_i & req_ready_o;
    // responses carry no ready and must arrive in request order.
    logic            live_q  [DEPTH];
    logic [4:0]      rd_q    [DEPTH];
    logic [3:0]      width_q [DEPTH];
    logic            sign_q  [DEPTH];
    logic [BW-1:0]   addr_q  [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [XLEN-1:0] fmt_data;
    logic            fmt_illegal;
    logic            head_writes;
    logic [31:0]     pending;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = rd_ptr[PW-1:0];
    assign tail  = wr_ptr[PW-1:0];

    // Readiness ignores a same-cycle pop so req_ready_o never depends on rsp_valid_i
    assign req_ready_o  = ~full & ~flush_i;
    assign push         = req_valid_i & req_ready_o;
    assign pop          = rsp_valid_i & ~empty;
    assign pipe_stall_o = pipe_valid_i & pop;
    assign head_writes  = live_q[head] & (rd_q[head] != 5'd0) & ~flush_i;

    load_slicer #(.XLEN(XLEN)) u_slicer (
        .rdata     (rsp_rdata_i),
        .width_1h  (width_q[head]),
        .sign      (sign_q[head]),
        .byte_addr (addr_q[head]),
        .data      (fmt_data),
        .illegal   (fmt_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i]  <= 1'b0;
                rd_q[i]    <= '0;
                width_q[i] <= '0;
                sign_q[i]  <= 1'b0;
                addr_q[i]  <= '0;
            end
        end else begin
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    live_q[i] <= 1'b0;
                end
            end
            // pop and push never alias: pop needs non-empty, push needs non-full
            if (pop) begin
                live_q[head] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (push) begin
                live_q[tail]  <= 1'b1;
                rd_q[tail]    <= req_rd_idx_i;
                width_q[tail] <= req_width_1h_i;
                sign_q[tail]  <= req_sign_i;
                addr_q[tail]  <= req_byte_addr_i;
                wr_ptr        <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_wr_en_o <= 1'b0;
            rd_idx_o   <= '0;
            rd_data_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            if (pop) begin
                rd_wr_en_o <= head_writes;
                rd_idx_o   <= rd_q[head];
                rd_data_o  <= fmt_data;
            end else if (pipe_valid_i) begin
                rd_wr_en_o <= (pipe_rd_idx_i != 5'd0);
                rd_idx_o   <= pipe_rd_idx_i;
                rd_data_o  <= pipe_rd_data_i;
            end else begin
                rd_wr_en_o <= 1'b0;
            end
            if ((rsp_valid_i && empty) || (pop && fmt_illegal)) begin
                err_o <= 1'b1;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending[rd_q[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    assign pending_o = pending;

endmodule

// File: tb/tb_load_writeback_queue.sv
// Randomized and directed bench for load_writeback_queue against a queue-of-loads
// reference model with arithmetic load formatting.
module tb_load_writeback_queue;
    import load_writeback_queue_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [4:0]      req_rd_idx_i = '0;
    logic [3:0]      req_width_1h_i = '0;
    logic            req_sign_i = 1'b0;
    logic [2:0]      req_byte_addr_i = '0;
    logic            rsp_valid_i = 1'b0;
    logic [63:0]     rsp_rdata_i = '0;
    logic            pipe_valid_i = 1'b0;
    logic [4:0]      pipe_rd_idx_i = '0;
    logic [63:0]     pipe_rd_data_i = '0;
    logic            pipe_stall_o;
    logic [63:0]     rd_data_o;
    logic [4:0]      rd_idx_o;
    logic            rd_wr_en_o;
    logic [31:0]     pending_o;
    logic            err_o;

    load_writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_rd_idx_i    (req_rd_idx_i),
        .req_width_1h_i  (req_width_1h_i),
        .req_sign_i      (req_sign_i),
        .req_byte_addr_i (req_byte_addr_i),
        .rsp_valid_i     (rsp_valid_i),
        .rsp_rdata_i     (rsp_rdata_i),
        .pipe_valid_i    (pipe_valid_i),
        .pipe_rd_idx_i   (pipe_rd_idx_i),
        .pipe_rd_data_i  (pipe_rd_data_i),
        .pipe_stall_o    (pipe_stall_o),
        .rd_data_o       (rd_data_o),
        .rd_idx_o        (rd_idx_o),
        .rd_wr_en_o      (rd_wr_en_o),
        .pending_o       (pending_o),
        .err_o           (err_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // reference model: outstanding loads in issue order
    typedef struct {
        logic       live;
        logic [4:0] rd;
        logic [3:0] w;
        logic       s;
        logic [2:0] a;
    } ent_t;

    ent_t        mq[$];
    logic [68:0] exp_q[$];
    logic        m_err;
    int          total = 0;
    int          bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_fmt(input logic [63:0] raw, input logic [3:0] w,
                                              input logic s, input logic [2:0] a,
                                              output logic illegal);
        int          n;
        int          off;
        logic [63:0] v;
        logic [63:0] lim;
        illegal = 1'b0;
        n = 0;
        if (w == 4'b0001) n = 1;
        else if (w == 4'b0010) n = 2;
        else if (w == 4'b0100) n = 4;
        else if (w == 4'b1000) n = 8;
        if (n == 0) begin
            illegal = 1'b1;
            return 64'd0;
        end
        off = (int'(a) / n) * n;
        v = raw >> (8 * off);
        if (n < 8) begin
            lim = 64'd1 << (8 * n);
            v = v % lim;
            if (s && v >= lim / 2) v = v - lim;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) if (mq[i].live && mq[i].rd != 5'd0) p[mq[i].rd] = 1'b1;
        return p;
    endfunction

    // driver: one clock of stimulus, combinational checks, model step, registered checks
    task automatic cycle(input logic rv, input logic [4:0] rrd, input logic [3:0] rw,
                         input logic rs, input logic [2:0] ra,
                         input logic sv, input logic [63:0] sd,
                         input logic pv, input logic [4:0] prd, input logic [63:0] pd,
                         input logic fl);
        logic        exp_ready;
        logic        exp_stall;
        logic        ill;
        logic [63:0] d;
        logic [68:0] x;
        ent_t        e;
        req_valid_i = rv; req_rd_idx_i = rrd; req_width_1h_i = rw;
        req_sign_i = rs; req_byte_addr_i = ra;
        rsp_valid_i = sv; rsp_rdata_i = sd;
        pipe_valid_i = pv; pipe_rd_idx_i = prd; pipe_rd_data_i = pd;
        flush_i = fl;
        #1;
        exp_ready = (mq.size() < DEPTH) && !fl;
        exp_stall = pv && sv && (mq.size() > 0);
        check_val("req_ready", 64'(req_ready_o), 64'(exp_ready));
        check_val("pipe_stall", 64'(pipe_stall_o), 64'(exp_stall));
        check_val("pending", 64'(pending_o), 64'(model_pending()));
        if (sv) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                d = model_fmt(sd, e.w, e.s, e.a, ill);
                if (ill) m_err = 1'b1;
                if (e.live && e.rd != 5'd0 && !fl) exp_q.push_back({e.rd, d});
            end else begin
                m_err = 1'b1;
            end
        end
        if (pv && !exp_stall && prd != 5'd0) exp_q.push_back({prd, pd});
        if (fl) foreach (mq[i]) mq[i].live = 1'b0;
        if (rv && exp_ready) mq.push_back('{1'b1, rrd, rw, rs, ra});
        @(posedge clk_i);
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check_val("wr_en", 64'(rd_wr_en_o), 64'd1);
            check_val("rd_idx", 64'(rd_idx_o), 64'(x[68:64]));
            check_val("rd_data", rd_data_o, x[63:0]);
        end else begin
            check_val("wr_en_idle", 64'(rd_wr_en_o), 64'd0);
        end
        check_val("err", 64'(err_o), 64'(m_err));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = 0; rsp_valid_i = 0; pipe_valid_i = 0; flush_i = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mq.delete();
        exp_q.delete();
        m_err = 1'b0;
        check_val("rst_wr_en", 64'(rd_wr_en_o), 64'd0);
        check_val("rst_rd_idx", 64'(rd_idx_o), 64'd0);
        check_val("rst_rd_data", rd_data_o, 64'd0);
        check_val("rst_err", 64'(err_o), 64'd0);
        check_val("rst_pending", 64'(pending_o), 64'd0);
    endtask

    initial begin
        logic [63:0] rdat;
        logic        rsp;
        do_reset();

        // LB rd5 addr3 signed
        cycle(1, 5, MEM_WIDTH_1H_BYTE, MEM_SIGNED, 3, 0, 0, 0, 0, 0, 0);
        check_val("lb_pending", 64'(pending_o), 64'h20);
        cycle(0, 0, 0, 0, 0, 1, 64'h0000_0000_80FF_0000, 0, 0, 0, 0);
        check_val("lb_value", rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);

        // LWU rd7 addr4 then LH rd8 addr6 signed
        cycle(1, 7, MEM_WIDTH_1H_WORD, MEM_UNSIGNED, 4, 0, 0, 0, 0, 0, 0);
        cycle(1, 8, MEM_WIDTH_1H_HALF, MEM_SIGNED, 6, 0, 0, 0, 0, 0, 0);
        check_val("lw_pending", 64'(pending_o), 64'h180);
        cycle(0, 0, 0, 0, 0, 1, 64'h8123_4567_0000_0000, 0, 0, 0, 0);
        check_val("lwu_value", rd_data_o, 64'h0000_0000_8123_4567);
        check_val("lwu_pending", 64'(pending_o), 64'h100);
        cycle(0, 0, 0, 0, 0, 1, 64'h8123_4567_0000_0000, 0, 0, 0, 0);
        check_val("lh_value", rd_data_o, 64'hFFFF_FFFF_FFFF_8123);

        // fill to DEPTH, pop while full, then ready returns
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 5'(10 + i), MEM_WIDTH_1H_DOUBLE, MEM_UNSIGNED, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 20, MEM_WIDTH_1H_BYTE, MEM_UNSIGNED, 0, 1, 64'hA5, 0, 0, 0, 0);
        cycle(1, 21, MEM_WIDTH_1H_BYTE, MEM_UNSIGNED, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 0, 0, 0, 0, 1, 64'(64'h1111 * (i + 1)), 0, 0, 0, 0);

        // pipe result collides with LD response
        cycle(1, 4, MEM_WIDTH_1H_DOUBLE, MEM_SIGNED, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 64'hDEAD_BEEF_0123_4567, 1, 3, 64'h11, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 64'h11, 0);
        check_val("pipe_value", rd_data_o, 64'h11);

        // flush with two loads queued
        cycle(1, 12, MEM_WIDTH_1H_WORD, MEM_SIGNED, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 13, MEM_WIDTH_1H_WORD, MEM_SIGNED, 4, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_val("flush_pending", 64'(pending_o), 64'd0);
        cycle(0, 0, 0, 0, 0, 1, 64'h1, 0, 0, 0, 0);
        cycle(1, 14, MEM_WIDTH_1H_BYTE, MEM_UNSIGNED, 7, 1, 64'h2, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 64'h7700_0000_0000_0000, 0, 0, 0, 0);

        // rd=0 load pops silently
        cycle(1, 0, MEM_WIDTH_1H_WORD, MEM_UNSIGNED, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rsp = ($urandom_range(0, 1) == 1) && (mq.size() > 0);
            rdat = {$urandom(), $urandom()};
            cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                  4'(1 << $urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), rsp, rdat,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)),
                  {$urandom(), $urandom()}, $urandom_range(0, 19) == 0);
        end
        while (mq.size() > 0) cycle(0, 0, 0, 0, 0, 1, {$urandom(), $urandom()}, 0, 0, 0, 0);
        idle();

        // error paths
        cycle(1, 9, 4'b0011, MEM_SIGNED, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 64'hFFFF, 0, 0, 0, 0);
        check_val("illegal_err", 64'(err_o), 64'd1);
        do_reset();
        cycle(1, 6, MEM_WIDTH_1H_BYTE, MEM_UNSIGNED, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 7, MEM_WIDTH_1H_BYTE, MEM_UNSIGNED, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 0, 1, 64'h55, 0, 0, 0, 0);
        check_val("empty_rsp_err", 64'(err_o), 64'd1);
        idle();
        idle();
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
